fetch_next_pc: RTL and testbench

// - Fetch-stage PC generator immediately upstream of the branch target buffer.
// - Drives the BTB lookup PC and picks the next fetch PC: BTB target on hit, else PC+2.
// - Tracks in-flight predictions in a FIFO and checks them against execute-stage resolutions.
// - Issues redirect/flush on mispredict and produces BTB update writes.

---
 rtl/fetch_next_pc_if.sv | 41 ++++
 rtl/fetch_next_pc.sv | 169 ++++++++++++++++
 tb/tb_fetch_next_pc.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_next_pc_if.sv
// Fetch-stage bus: BTB lookup, fetch, execute resolution, redirect, BTB update and perf ports.
// master = fetch_next_pc, slave = surrounding BTB/execute/pipeline environment.
interface fetch_next_pc_if;
    logic        stall;
    logic        btb_hit;
    logic [15:0] btb_predicted_pc;
    logic [15:0] btb_read_pc;
    logic [15:0] fetch_pc;
    logic        fetch_valid;
    logic        resolve_valid;
    logic        resolve_is_branch;
    logic        resolve_taken;
    logic [15:0] resolve_target;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        btb_write;
    logic [15:0] btb_write_pc;
    logic [15:0] btb_write_data;
    logic        btb_taken;
    logic        queue_full;
    logic [15:0] perf_branches;
    logic [15:0] perf_mispredicts;

    modport master (
        input  stall, btb_hit, btb_predicted_pc,
        input  resolve_valid, resolve_is_branch, resolve_taken, resolve_target,
        output btb_read_pc, fetch_pc, fetch_valid,
        output redirect, redirect_pc,
        output btb_write, btb_write_pc, btb_write_data, btb_taken,
        output queue_full, perf_branches, perf_mispredicts
    );

    modport slave (
        output stall, btb_hit, btb_predicted_pc,
        output resolve_valid, resolve_is_branch, resolve_taken, resolve_target,
        input  btb_read_pc, fetch_pc, fetch_valid,
        input  redirect, redirect_pc,
        input  btb_write, btb_write_pc, btb_write_data, btb_taken,
        input  queue_full, perf_branches, perf_mispredicts
    );
endinterface

// File: rtl/fetch_next_pc.sv
// Fetch PC generator with prediction queue, mispredict redirect and BTB update.
// Optional FETCH_PERF_CNT_EN builds saturating branch/mispredict counters.
module fetch_next_pc #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            reset_n,
    fetch_next_pc_if.master fp
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {ST_RUN, ST_REDIRECT} state_t;

    state_t             state_reg, state_next;
    logic [15:0]        pc_reg, pc_next;
    logic [PTR_W-1:0]   head_reg, head_next;
    logic [PTR_W-1:0]   tail_reg, tail_next;
    logic [CNT_W-1:0]   count_reg, count_next;

    logic [15:0]        q_pc   [DEPTH];
    logic [15:0]        q_pred [DEPTH];

    logic               redirect_reg;
    logic [15:0]        redirect_pc_reg;
    logic               btb_write_reg;
    logic [15:0]        btb_write_pc_reg;
    logic [15:0]        btb_write_data_reg;

    logic               queue_full;
    logic               queue_empty;
    logic               fire;
    logic [15:0]        pred_next;
    logic               deq;
    logic [15:0]        head_pc;
    logic [15:0]        head_pred;
    logic               resolved_taken;
    logic [15:0]        actual_next;
    logic               mispredict;
    logic               btb_update;

    assign queue_full  = (count_reg == CNT_W'(DEPTH));
    assign queue_empty = (count_reg == '0);
    assign fire        = (state_reg == ST_RUN) && !fp.stall && !queue_full;
    assign pred_next   = fp.btb_hit ? fp.btb_predicted_pc : pc_reg + 16'd2;

    assign deq            = fp.resolve_valid && !queue_empty;
    assign head_pc        = q_pc[head_reg];
    assign head_pred      = q_pred[head_reg];
    assign resolved_taken = fp.resolve_is_branch && fp.resolve_taken;
    assign actual_next    = resolved_taken ? fp.resolve_target : head_pc + 16'd2;
    assign mispredict     = deq && (actual_next != head_pred);
    assign btb_update     = deq && resolved_taken;

    always_comb begin
        state_next = ST_RUN;
        case (state_reg)
            ST_RUN:      state_next = mispredict ? ST_REDIRECT : ST_RUN;
            ST_REDIRECT: state_next = ST_RUN;
            default:     state_next = ST_RUN;
        endcase
    end

    // A mispredict wipes the queue, including an entry fetched in the same cycle.
    always_comb begin
        pc_next    = pc_reg;
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (mispredict) begin
            pc_next    = actual_next;
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (fire) begin
                pc_next   = pred_next;
                tail_next = tail_reg + PTR_W'(1);
            end
            if (deq) begin
                head_next = head_reg + PTR_W'(1);
            end
            if (fire && !deq) begin
                count_next = count_reg + CNT_W'(1);
            end else if (!fire && deq) begin
                count_next = count_reg - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg          <= ST_RUN;
            pc_reg             <= RESET_PC;
            head_reg           <= '0;
            tail_reg           <= '0;
            count_reg          <= '0;
            redirect_reg       <= 1'b0;
            redirect_pc_reg    <= 16'h0000;
            btb_write_reg      <= 1'b0;
            btb_write_pc_reg   <= 16'h0000;
            btb_write_data_reg <= 16'h0000;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            head_reg      <= head_next;
            tail_reg      <= tail_next;
            count_reg     <= count_next;
            redirect_reg  <= mispredict;
            btb_write_reg <= btb_update;
            if (mispredict) begin
                redirect_pc_reg <= actual_next;
            end
            if (btb_update) begin
                btb_write_pc_reg   <= head_pc;
                btb_write_data_reg <= fp.resolve_target;
            end
        end
    end

    // Entry storage carries no reset; occupancy is tracked solely by the pointers.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (fire && (tail_reg == PTR_W'(gi))) begin
                    q_pc[gi]   <= pc_reg;
                    q_pred[gi] <= pred_next;
                end
            end
        end
    endgenerate

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_branches_reg;
    logic [15:0] perf_mispredicts_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_branches_reg    <= 16'h0000;
            perf_mispredicts_reg <= 16'h0000;
        end else begin
            if (deq && fp.resolve_is_branch && (perf_branches_reg != 16'hFFFF)) begin
                perf_branches_reg <= perf_branches_reg + 16'd1;
            end
            if (mispredict && (perf_mispredicts_reg != 16'hFFFF)) begin
                perf_mispredicts_reg <= perf_mispredicts_reg + 16'd1;
            end
        end
    end

    assign fp.perf_branches    = perf_branches_reg;
    assign fp.perf_mispredicts = perf_mispredicts_reg;
`else
    assign fp.perf_branches    = 16'h0000;
    assign fp.perf_mispredicts = 16'h0000;
`endif

    assign fp.btb_read_pc    = pc_reg;
    assign fp.fetch_pc       = pc_reg;
    assign fp.fetch_valid    = fire;
    assign fp.queue_full     = queue_full;
    assign fp.redirect       = redirect_reg;
    assign fp.redirect_pc    = redirect_pc_reg;
    assign fp.btb_write      = btb_write_reg;
    assign fp.btb_write_pc   = btb_write_pc_reg;
    assign fp.btb_write_data = btb_write_data_reg;
    assign fp.btb_taken      = btb_write_reg;
endmodule

// File: tb/tb_fetch_next_pc.sv
// Randomized scoreboard bench for fetch_next_pc: a queue-based reference model
// predicts fetch, redirect and BTB-write events; a negedge monitor pops and compares.
module tb_fetch_next_pc;
    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;
`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fetch_next_pc_if bus ();

    fetch_next_pc #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .fp      (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    typedef struct { logic [15:0] pc; logic [15:0] nxt; } ent_t;
    typedef struct { int cyc; logic [15:0] a; logic [15:0] b; } ev_t;
    typedef struct { int cyc; bit full; logic [15:0] br; logic [15:0] mis; } st_t;

    ent_t mq[$];
    ev_t  fq[$];
    ev_t  rq[$];
    ev_t  wq[$];
    st_t  sq[$];
    logic [15:0] m_pc;
    bit          m_redir;
    int          m_br;
    int          m_mis;

    task automatic chk(input string name, input bit ok, input string detail);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    function automatic logic [15:0] rnd_pc();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 7) == 0) return 16'hFFFE;
        return r[15:0] & 16'hFFFE;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc    = RESET_PC;
        m_redir = 1'b0;
        m_br    = 0;
        m_mis   = 0;
    endtask

    // One clock of the reference model, using the inputs currently driven on the bus.
    task automatic step();
        st_t s;
        ev_t e;
        ent_t h, n;
        logic [15:0] pred, act;
        bit fire, deq, mis, brt;
        s.cyc  = cyc;
        s.full = (mq.size() == DEPTH);
        s.br   = PERF ? 16'(m_br) : 16'h0000;
        s.mis  = PERF ? 16'(m_mis) : 16'h0000;
        sq.push_back(s);
        fire = !m_redir && !bus.stall && (mq.size() < DEPTH);
        if (fire) begin
            e.cyc = cyc; e.a = m_pc; e.b = 16'h0000;
            fq.push_back(e);
        end
        pred = bus.btb_hit ? bus.btb_predicted_pc : m_pc + 16'd2;
        deq  = bus.resolve_valid && (mq.size() > 0);
        mis  = 1'b0;
        act  = 16'h0000;
        if (deq) begin
            h   = mq[0];
            brt = bus.resolve_is_branch && bus.resolve_taken;
            act = brt ? bus.resolve_target : h.pc + 16'd2;
            mis = (act != h.nxt);
            if (brt) begin
                e.cyc = cyc + 1; e.a = h.pc; e.b = bus.resolve_target;
                wq.push_back(e);
            end
            if (bus.resolve_is_branch && m_br < 65535) m_br++;
            if (mis) begin
                e.cyc = cyc + 1; e.a = act; e.b = 16'h0000;
                rq.push_back(e);
                if (m_mis < 65535) m_mis++;
            end
        end
        if (mis) begin
            mq.delete();
            m_pc    = act;
            m_redir = 1'b1;
        end else begin
            if (deq) void'(mq.pop_front());
            if (fire) begin
                n.pc = m_pc; n.nxt = pred;
                mq.push_back(n);
                m_pc = pred;
            end
            m_redir = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        bus.stall = 1'b1; bus.btb_hit = 1'b0; bus.btb_predicted_pc = 16'h0000;
        bus.resolve_valid = 1'b0; bus.resolve_is_branch = 1'b0;
        bus.resolve_taken = 1'b0; bus.resolve_target = 16'h0000;
    endtask

    // Asserts reset mid-cycle; strobes expected at or after this cycle are discarded.
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        idle_inputs();
        while (fq.size() > 0 && fq[$].cyc >= cyc) void'(fq.pop_back());
        while (rq.size() > 0 && rq[$].cyc >= cyc) void'(rq.pop_back());
        while (wq.size() > 0 && wq[$].cyc >= cyc) void'(wq.pop_back());
        model_reset();
        step();
        #1;
        chk("reset_pc", bus.fetch_pc == RESET_PC,
            $sformatf("fetch_pc got %h want %h", bus.fetch_pc, RESET_PC));
        chk("reset_strobes", {bus.redirect, bus.btb_write, bus.btb_taken, bus.queue_full} == 4'b0,
            $sformatf("redirect/btb_write/btb_taken/queue_full got %b%b%b%b want 0000",
                      bus.redirect, bus.btb_write, bus.btb_taken, bus.queue_full));
        chk("reset_data", {bus.redirect_pc, bus.btb_write_pc, bus.btb_write_data} == 48'h0,
            $sformatf("redirect_pc %h btb_write_pc %h btb_write_data %h want 0",
                      bus.redirect_pc, bus.btb_write_pc, bus.btb_write_data));
        chk("reset_perf", {bus.perf_branches, bus.perf_mispredicts} == 32'h0,
            $sformatf("perf got %h/%h want 0/0", bus.perf_branches, bus.perf_mispredicts));
        repeat (2) begin
            @(negedge clk);
            step();
        end
        reset_n = 1'b1;
    endtask

    task automatic rnd_cycle(input int p_stall, input int p_res);
        ent_t h;
        int r;
        @(negedge clk);
        bus.stall            = ($urandom_range(0, 99) < p_stall);
        bus.btb_hit          = ($urandom_range(0, 3) == 0);
        bus.btb_predicted_pc = rnd_pc();
        bus.resolve_valid    = ($urandom_range(0, 99) < p_res);
        bus.resolve_is_branch = 1'b0;
        bus.resolve_taken    = 1'b0;
        bus.resolve_target   = rnd_pc();
        r = $urandom_range(0, 5);
        if (mq.size() > 0 && r <= 2) begin
            h = mq[0];
            if (h.nxt == h.pc + 16'd2) begin
                bus.resolve_is_branch = 1'($urandom_range(0, 1));
            end else begin
                bus.resolve_is_branch = 1'b1;
                bus.resolve_taken     = 1'b1;
                bus.resolve_target    = h.nxt;
            end
        end else if (r == 3) begin
            bus.resolve_taken = 1'($urandom_range(0, 1));
        end else if (r == 4) begin
            bus.resolve_is_branch = 1'b1;
            bus.resolve_taken     = 1'b1;
        end else begin
            bus.resolve_is_branch = 1'b1;
        end
        step();
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues each cycle.
    initial begin
        st_t s;
        ev_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sq.size() > 0 && sq[0].cyc == cyc) begin
                s = sq.pop_front();
                chk("status", bus.queue_full == s.full && bus.perf_branches == s.br &&
                    bus.perf_mispredicts == s.mis && bus.btb_taken == bus.btb_write,
                    $sformatf("cyc %0d full %b br %h mis %h taken %b want full %b br %h mis %h taken %b",
                              cyc, bus.queue_full, bus.perf_branches, bus.perf_mispredicts,
                              bus.btb_taken, s.full, s.br, s.mis, bus.btb_write));
            end else begin
                chk("status_missing", 1'b0, $sformatf("no model status for cyc %0d", cyc));
            end
            if (bus.fetch_valid) begin
                if (fq.size() == 0) chk("fetch_extra", 1'b0, $sformatf("cyc %0d fetch %h unexpected", cyc, bus.fetch_pc));
                else begin
                    e = fq.pop_front();
                    chk("fetch", e.cyc == cyc && bus.fetch_pc == e.a && bus.btb_read_pc == e.a,
                        $sformatf("cyc %0d pc %h btb_read_pc %h want cyc %0d pc %h",
                                  cyc, bus.fetch_pc, bus.btb_read_pc, e.cyc, e.a));
                end
            end else if (fq.size() > 0 && fq[0].cyc <= cyc) begin
                e = fq.pop_front();
                chk("fetch_missing", 1'b0, $sformatf("cyc %0d fetch_valid 0 want fetch of %h", cyc, e.a));
            end
            if (bus.redirect) begin
                if (rq.size() == 0) chk("redirect_extra", 1'b0, $sformatf("cyc %0d redirect to %h unexpected", cyc, bus.redirect_pc));
                else begin
                    e = rq.pop_front();
                    chk("redirect", e.cyc == cyc && bus.redirect_pc == e.a,
                        $sformatf("cyc %0d redirect_pc %h want cyc %0d pc %h", cyc, bus.redirect_pc, e.cyc, e.a));
                end
            end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
                e = rq.pop_front();
                chk("redirect_missing", 1'b0, $sformatf("cyc %0d redirect 0 want redirect to %h", cyc, e.a));
            end
            if (bus.btb_write) begin
                if (wq.size() == 0) chk("btbw_extra", 1'b0, $sformatf("cyc %0d btb_write %h->%h unexpected", cyc, bus.btb_write_pc, bus.btb_write_data));
                else begin
                    e = wq.pop_front();
                    chk("btbw", e.cyc == cyc && bus.btb_write_pc == e.a && bus.btb_write_data == e.b && bus.btb_taken,
                        $sformatf("cyc %0d write %h->%h taken %b want cyc %0d %h->%h taken 1",
                                  cyc, bus.btb_write_pc, bus.btb_write_data, bus.btb_taken, e.cyc, e.a, e.b));
                end
            end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
                e = wq.pop_front();
                chk("btbw_missing", 1'b0, $sformatf("cyc %0d btb_write 0 want %h->%h", cyc, e.a, e.b));
            end
        end
    end

    initial begin
        idle_inputs();
        model_reset();
        do_reset();
        // Straight-line fetch from reset: 0000, 0002, 0004.
        repeat (3) begin
            @(negedge clk);
            bus.stall = 1'b0; bus.btb_hit = 1'b0; bus.resolve_valid = 1'b0;
            step();
        end
        for (int p = 0; p < 4; p++) begin
            int ps, pr;
            ps = (p == 0) ? 10 : (p == 1) ? 30 : (p == 2) ? 0 : 20;
            pr = (p == 0) ? 50 : (p == 1) ? 20 : (p == 2) ? 90 : 70;
            repeat (400) rnd_cycle(ps, pr);
            do_reset();
        end
        repeat (20) rnd_cycle(10, 50);
        repeat (3) begin
            @(negedge clk);
            idle_inputs();
            step();
        end
        #3;
        chk("drain", fq.size() == 0 && rq.size() == 0 && wq.size() == 0,
            $sformatf("pending fetch %0d redirect %0d btbw %0d want 0/0/0", fq.size(), rq.size(), wq.size()));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
